join_sync: RTL

//  Inverse of the DMAC handshake fork: merges C_NUM_S independent valid/ready

---
 rtl/join_sync_pkg.sv | 14 +
 rtl/join_sync_cnt.sv | 45 ++++
 rtl/join_sync.sv | 38 +++
 3 files changed

// File: rtl/join_sync_pkg.sv
// Shared helpers for the token-join block.
package join_sync_pkg;

  // Ceiling log2, usable in constant expressions; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/join_sync_cnt.sv
// One input's pending-token counter with its accept and empty/non-empty flags.
module join_sync_cnt
  import join_sync_pkg::*;
#(
  parameter int unsigned C_MAX_PENDING = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic s_valid,
  input  logic dec,
  output logic s_ready,
  output logic nonzero,
  output logic zero
);

  localparam int unsigned C_CNT_W = clog2(C_MAX_PENDING + 1);
  localparam logic [C_CNT_W-1:0] CntMax = C_CNT_W'(C_MAX_PENDING);

  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               inc;

  // A full counter still accepts when the joined token leaves this cycle.
  assign s_ready = (cnt_q != CntMax) | dec;
  assign inc     = s_valid & s_ready;
  assign nonzero = (cnt_q != '0);
  assign zero    = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + C_CNT_W'(1);
    end else if (!inc && dec) begin
      cnt_d = cnt_q - C_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/join_sync.sv
// Joins C_NUM_S valid/ready token streams: one output token per token from every input.
module join_sync #(
  parameter int unsigned C_NUM_S       = 2,
  parameter int unsigned C_MAX_PENDING = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [C_NUM_S-1:0] s_valid,
  output logic [C_NUM_S-1:0] s_ready,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               idle
);

  logic [C_NUM_S-1:0] nonzero;
  logic [C_NUM_S-1:0] zero;
  logic               dec;

  // m_valid depends only on counter state, never on s_valid.
  assign m_valid = &nonzero;
  assign idle    = &zero;
  assign dec     = m_valid & m_ready;

  for (genvar i = 0; i < C_NUM_S; i++) begin : g_cnt
    join_sync_cnt #(
      .C_MAX_PENDING(C_MAX_PENDING)
    ) u_cnt (
      .clk    (clk),
      .resetn (resetn),
      .s_valid(s_valid[i]),
      .dec    (dec),
      .s_ready(s_ready[i]),
      .nonzero(nonzero[i]),
      .zero   (zero[i])
    );
  end

endmodule
